dense_controller: RTL and testbench

DENSE_CONTROLLER -- requirements
Module: dense_controller

---
 rtl/dense_controller.sv | 160 ++++++++++++++++
 tb/tb_dense_controller.sv | 260 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/dense_controller.sv
// Sequencing FSM for one fully-connected layer: drives activation/weight reads and accumulator strobes.
// Optional bias-add stage is compiled in when DENSE_CTRL_BIAS_EN is defined.
module dense_controller #(
    parameter int IN_SIZE  = 16,
    parameter int OUT_SIZE = 10,
    parameter int IN_AW    = 8,
    parameter int W_AW     = 12,
    parameter int OUT_AW   = 4
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              start,
    input  logic              abort,
    output logic [IN_AW-1:0]  inAddr,
    output logic [W_AW-1:0]   wAddr,
    output logic              accClr,
    output logic              accLd,
    output logic [OUT_AW-1:0] biasAddr,
    output logic              biasLd,
    output logic [OUT_AW-1:0] outAddr,
    output logic              outWr,
    output logic              busy,
    output logic              done
);

`ifdef DENSE_CTRL_BIAS_EN
    localparam bit BIAS_EN = 1'b1;
`else
    localparam bit BIAS_EN = 1'b0;
`endif

    localparam int                CW        = (IN_SIZE > 1) ? $clog2(IN_SIZE) : 1;
    localparam logic [CW-1:0]     MAC_LAST  = CW'(IN_SIZE - 1);
    localparam logic [OUT_AW-1:0] OUT_LAST  = OUT_AW'(OUT_SIZE - 1);
    localparam logic [W_AW-1:0]   W_STEP    = W_AW'(IN_SIZE);
    localparam logic [IN_AW-1:0]  IN_FIRST  = (IN_SIZE > 1) ? IN_AW'(1) : '0;
    localparam logic [W_AW-1:0]   W_FIRST   = (IN_SIZE > 1) ? W_AW'(1) : '0;

    typedef enum logic [2:0] {IDLE, CLR, MAC, BIAS, WRITE, DONE} state_t;

    state_t              state_q;
    logic [CW-1:0]       mac_cnt_q;
    logic [OUT_AW-1:0]   out_idx_q;
    logic [W_AW-1:0]     w_base_q;
    logic [IN_AW-1:0]    in_addr_q;
    logic [W_AW-1:0]     w_addr_q;
    logic [OUT_AW-1:0]   out_addr_q;
    logic [OUT_AW-1:0]   bias_addr_q;
    logic                acc_clr_q, acc_ld_q, bias_ld_q, out_wr_q, busy_q, done_q;

    // Addresses are issued one cycle ahead of the strobe that consumes the read data;
    // on the last MAC cycle they hold so wAddr never leaves the weight array.
    always_ff @(posedge clk or posedge rst) begin
        if (rst || abort) begin
            state_q     <= IDLE;
            mac_cnt_q   <= '0;
            out_idx_q   <= '0;
            w_base_q    <= '0;
            in_addr_q   <= '0;
            w_addr_q    <= '0;
            out_addr_q  <= '0;
            bias_addr_q <= '0;
            acc_clr_q   <= 1'b0;
            acc_ld_q    <= 1'b0;
            bias_ld_q   <= 1'b0;
            out_wr_q    <= 1'b0;
            busy_q      <= 1'b0;
            done_q      <= 1'b0;
        end else begin
            acc_clr_q <= 1'b0;
            acc_ld_q  <= 1'b0;
            bias_ld_q <= 1'b0;
            out_wr_q  <= 1'b0;
            done_q    <= 1'b0;
            case (state_q)
                IDLE: begin
                    if (start) begin
                        state_q     <= CLR;
                        busy_q      <= 1'b1;
                        acc_clr_q   <= 1'b1;
                        out_idx_q   <= '0;
                        w_base_q    <= '0;
                        in_addr_q   <= '0;
                        w_addr_q    <= '0;
                        bias_addr_q <= '0;
                    end
                end
                CLR: begin
                    state_q   <= MAC;
                    acc_ld_q  <= 1'b1;
                    mac_cnt_q <= '0;
                    in_addr_q <= IN_FIRST;
                    w_addr_q  <= w_base_q + W_FIRST;
                end
                MAC: begin
                    if (mac_cnt_q == MAC_LAST) begin
                        if (BIAS_EN) begin
                            state_q   <= BIAS;
                            bias_ld_q <= 1'b1;
                        end else begin
                            state_q    <= WRITE;
                            out_wr_q   <= 1'b1;
                            out_addr_q <= out_idx_q;
                        end
                    end else begin
                        mac_cnt_q <= mac_cnt_q + 1'b1;
                        acc_ld_q  <= 1'b1;
                        if (mac_cnt_q + 1'b1 != MAC_LAST) begin
                            in_addr_q <= in_addr_q + 1'b1;
                            w_addr_q  <= w_addr_q + 1'b1;
                        end
                    end
                end
                BIAS: begin
                    state_q    <= WRITE;
                    out_wr_q   <= 1'b1;
                    out_addr_q <= out_idx_q;
                end
                WRITE: begin
                    if (out_idx_q == OUT_LAST) begin
                        state_q <= DONE;
                        done_q  <= 1'b1;
                    end else begin
                        state_q     <= CLR;
                        acc_clr_q   <= 1'b1;
                        out_idx_q   <= out_idx_q + 1'b1;
                        bias_addr_q <= out_idx_q + 1'b1;
                        w_base_q    <= w_base_q + W_STEP;
                        w_addr_q    <= w_base_q + W_STEP;
                        in_addr_q   <= '0;
                    end
                end
                DONE: begin
                    state_q     <= IDLE;
                    busy_q      <= 1'b0;
                    mac_cnt_q   <= '0;
                    out_idx_q   <= '0;
                    w_base_q    <= '0;
                    in_addr_q   <= '0;
                    w_addr_q    <= '0;
                    out_addr_q  <= '0;
                    bias_addr_q <= '0;
                end
                default: state_q <= IDLE;
            endcase
        end
    end

    assign inAddr   = in_addr_q;
    assign wAddr    = w_addr_q;
    assign accClr   = acc_clr_q;
    assign accLd    = acc_ld_q;
    assign biasLd   = BIAS_EN ? bias_ld_q : 1'b0;
    assign biasAddr = BIAS_EN ? bias_addr_q : '0;
    assign outAddr  = out_addr_q;
    assign outWr    = out_wr_q;
    assign busy     = busy_q;
    assign done     = done_q;

endmodule

// File: tb/tb_dense_controller.sv
// Scoreboard bench for dense_controller: a 4x3 layer instance and a 1x1 instance, directed then random stimulus.
module tb_dense_controller;
    localparam int IN0 = 4, OUT0 = 3, IN1 = 1, OUT1 = 1;
`ifdef DENSE_CTRL_BIAS_EN
    localparam int B = 1;
`else
    localparam int B = 0;
`endif

    typedef struct {int kind; int cyc; int a; int b;} ev_t; // kind 0 clr,1 ld,2 bias,3 wr,4 done

    logic clk = 1'b0;
    logic rst = 1'b1;
    logic start0 = 1'b0, start1 = 1'b0, abort0 = 1'b0, abort1 = 1'b0;
    logic [7:0]  ia0, ia1;
    logic [11:0] wa0, wa1;
    logic [3:0]  ba0, ba1, oa0, oa1;
    logic clr0, ld0, bl0, wr0, bz0, dn0;
    logic clr1, ld1, bl1, wr1, bz1, dn1;

    dense_controller #(.IN_SIZE(IN0), .OUT_SIZE(OUT0)) dut0 (
        .clk(clk), .rst(rst), .start(start0), .abort(abort0),
        .inAddr(ia0), .wAddr(wa0), .accClr(clr0), .accLd(ld0),
        .biasAddr(ba0), .biasLd(bl0), .outAddr(oa0), .outWr(wr0),
        .busy(bz0), .done(dn0));

    dense_controller #(.IN_SIZE(IN1), .OUT_SIZE(OUT1)) dut1 (
        .clk(clk), .rst(rst), .start(start1), .abort(abort1),
        .inAddr(ia1), .wAddr(wa1), .accClr(clr1), .accLd(ld1),
        .biasAddr(ba1), .biasLd(bl1), .outAddr(oa1), .outWr(wr1),
        .busy(bz1), .done(dn1));

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int checks = 0, errors = 0;
    ev_t q0[$], q1[$];
    int bfrom[2] = '{0, 0};
    int bto[2]   = '{-1, -1};
    int wap0 = 0, iap0 = 0, wap1 = 0, iap1 = 0;

    function automatic void push_ev(input int id, input int k, input int c, input int a, input int b);
        ev_t e;
        e.kind = k; e.cyc = c; e.a = a; e.b = b;
        if (id == 0) q0.push_back(e); else q1.push_back(e);
    endfunction

    function automatic void pop_ev(input int id, output bit have, output ev_t e);
        e = '{0, 0, 0, 0};
        if (id == 0) begin
            have = q0.size() > 0;
            if (have) e = q0.pop_front();
        end else begin
            have = q1.size() > 0;
            if (have) e = q1.pop_front();
        end
    endfunction

    function automatic void flush(input int id, input int c);
        ev_t t[$];
        if (id == 0) begin
            t = q0; q0.delete();
            foreach (t[j]) if (t[j].cyc < c) q0.push_back(t[j]);
        end else begin
            t = q1; q1.delete();
            foreach (t[j]) if (t[j].cyc < c) q1.push_back(t[j]);
        end
    endfunction

    // Reference: one layer is, per neuron, a clear, IN loads of weight n*IN+i, optional bias, a write.
    function automatic void model_layer(input int id, input int s);
        int inn, outn, t;
        inn  = (id == 0) ? IN0 : IN1;
        outn = (id == 0) ? OUT0 : OUT1;
        t = s + 1;
        bfrom[id] = t;
        for (int n = 0; n < outn; n++) begin
            push_ev(id, 0, t, n * inn, n); t++;
            for (int i = 0; i < inn; i++) begin
                push_ev(id, 1, t, n * inn + i, i); t++;
            end
            if (B != 0) begin push_ev(id, 2, t, n, 0); t++; end
            push_ev(id, 3, t, n, 0); t++;
        end
        push_ev(id, 4, t, s, 0);
        bto[id] = t;
    endfunction

    task automatic mon(input int id, input int inn, input int outn,
                       input logic clr, input logic ld, input logic bl, input logic wr,
                       input logic dn, input logic bz,
                       input int wa, input int ia, input int oa, input int ba,
                       input int wap, input int iap);
        ev_t e; bit have; bit eb; bit ok; int k;
        checks++;
        if ($countones({clr, ld, bl, wr}) > 1) begin
            errors++;
            $display("FAIL excl id=%0d cyc=%0d strobes=%b want at most one", id, cyc, {clr, ld, bl, wr});
        end
        eb = (cyc >= bfrom[id]) && (cyc <= bto[id]);
        checks++;
        if (bz !== eb) begin
            errors++;
            $display("FAIL busy id=%0d cyc=%0d got=%b want=%b", id, cyc, bz, eb);
        end
        if (!eb) begin
            checks++;
            if (ia != 0 || wa != 0 || oa != 0 || ba != 0) begin
                errors++;
                $display("FAIL idle_addr id=%0d cyc=%0d in=%0d w=%0d out=%0d bias=%0d want all 0", id, cyc, ia, wa, oa, ba);
            end
        end
        if (clr | ld | bl | wr | dn) begin
            k = ld ? 1 : clr ? 0 : bl ? 2 : wr ? 3 : 4;
            pop_ev(id, have, e);
            checks++;
            if (!have) begin
                errors++;
                $display("FAIL unexpected id=%0d cyc=%0d got kind=%0d want no strobe", id, cyc, k);
            end else if (e.kind != k || e.cyc != cyc) begin
                errors++;
                $display("FAIL event id=%0d got kind=%0d@%0d want kind=%0d@%0d", id, k, cyc, e.kind, e.cyc);
            end else begin
                checks++;
                case (k)
                    0: ok = (wa == e.a) && (ia == 0) && (ba == (B != 0 ? e.b : 0));
                    1: ok = (wap == e.a) && (iap == e.b) && (wa <= inn * outn - 1);
                    2: ok = (ba == e.a);
                    3: ok = (oa == e.a) && (ba == (B != 0 ? e.a : 0));
                    default: ok = (cyc - e.a == outn * (inn + 2 + B) + 1);
                endcase
                if (!ok) begin
                    errors++;
                    $display("FAIL detail id=%0d cyc=%0d kind=%0d got w=%0d in=%0d wprev=%0d inprev=%0d out=%0d bias=%0d want a=%0d b=%0d",
                             id, cyc, k, wa, ia, wap, iap, oa, ba, e.a, e.b);
                end
            end
        end
    endtask

    always @(negedge clk) begin
        mon(0, IN0, OUT0, clr0, ld0, bl0, wr0, dn0, bz0, int'(wa0), int'(ia0), int'(oa0), int'(ba0), wap0, iap0);
        mon(1, IN1, OUT1, clr1, ld1, bl1, wr1, dn1, bz1, int'(wa1), int'(ia1), int'(oa1), int'(ba1), wap1, iap1);
        wap0 = int'(wa0); iap0 = int'(ia0);
        wap1 = int'(wa1); iap1 = int'(ia1);
    end

    task automatic tick();
        @(posedge clk); #1;
    endtask

    task automatic wait_until(input int c);
        while (cyc < c) tick();
    endtask

    task automatic do_start(input int id, output int s);
        s = cyc;
        if (!rst && s > bto[id]) model_layer(id, s);
        if (id == 0) start0 = 1'b1; else start1 = 1'b1;
        tick();
        start0 = 1'b0; start1 = 1'b0;
    endtask

    task automatic do_abort(input int id);
        int c;
        c = cyc;
        if (c >= bfrom[id] && c <= bto[id]) begin
            flush(id, c + 1);
            bto[id] = c;
        end
        if (id == 0) abort0 = 1'b1; else abort1 = 1'b1;
        tick();
        abort0 = 1'b0; abort1 = 1'b0;
    endtask

    task automatic do_start_abort(input int id);
        if (id == 0) begin start0 = 1'b1; abort0 = 1'b1; end
        else begin start1 = 1'b1; abort1 = 1'b1; end
        tick();
        start0 = 1'b0; start1 = 1'b0; abort0 = 1'b0; abort1 = 1'b0;
    endtask

    task automatic check_zero(input string tag);
        checks++;
        if ({ia0, wa0, ba0, oa0, clr0, ld0, bl0, wr0, bz0, dn0,
             ia1, wa1, ba1, oa1, clr1, ld1, bl1, wr1, bz1, dn1} != '0) begin
            errors++;
            $display("FAIL %s got dut0=%h/%h/%b dut1=%h/%h/%b want all 0", tag,
                     wa0, ia0, {clr0, ld0, bl0, wr0, bz0, dn0}, wa1, ia1, {clr1, ld1, bl1, wr1, bz1, dn1});
        end
    endtask

    task automatic do_reset();
        int c;
        #2;
        rst = 1'b1;
        c = cyc;
        for (int id = 0; id < 2; id++) begin
            flush(id, c);
            if (bto[id] >= c) bto[id] = c - 1;
        end
        #1;
        check_zero("reset_async");
        tick(); tick();
        rst = 1'b0;
    endtask

    initial begin
        int s, t, r, id, g, lat0, lat1, nb, last;
        lat0 = OUT0 * (IN0 + 2 + B) + 1;
        lat1 = OUT1 * (IN1 + 2 + B) + 1;
        nb   = IN0 + 2 + B;

        repeat (3) tick();
        check_zero("reset_state");
        rst = 1'b0;
        tick();

        do_start(0, s); wait_until(s + lat0 + 2);

        do_start(0, s); wait_until(s + 1 + nb + 2);
        do_start(0, t); wait_until(s + lat0 + 2);

        do_start(0, s); wait_until(s + 1 + nb + 2);
        do_abort(0); repeat (3) tick();
        do_start(0, s); wait_until(s + lat0 + 2);

        do_start(0, s); wait_until(s + 2 + IN0 + B);
        do_reset();
        do_start(0, s); wait_until(s + lat0 + 2);

        do_start_abort(0); repeat (3) tick();

        do_start(1, s); wait_until(s + lat1 + 2);

        for (int it = 0; it < 60; it++) begin
            r  = $urandom_range(0, 19);
            id = $urandom_range(0, 1);
            if (r < 13)      do_start(id, s);
            else if (r < 17) do_abort(id);
            else if (r < 19) do_start_abort(id);
            else             do_reset();
            g = $urandom_range(0, 12);
            repeat (g) tick();
        end

        last = (bto[0] > bto[1]) ? bto[0] : bto[1];
        wait_until(last + 3);
        checks++;
        if (q0.size() != 0 || q1.size() != 0) begin
            errors++;
            $display("FAIL drain got pending=%0d/%0d want 0/0", q0.size(), q1.size());
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
